// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   ICACHE_LINES / INDEX_W / TAG_W : direct-mapped I-cache geometry
//                                    (one 32-bit word per line, 18-bit physical space)
//   fetch_state_e                  : fetch FSM encodings
//   fetch_addr()                   : byte address of the current miss byte
package if_fetch_pkg;

    localparam int ICACHE_LINES = 128;
    localparam int INDEX_W      = 7;
    localparam int TAG_W        = 9;
    localparam int ADDR_W       = 32;
    localparam int INST_W       = 32;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        S_LOOKUP = 2'd0,
        S_FETCH  = 2'd1,
        S_FILL   = 2'd2
    } fetch_state_e;

    // The miss PC is word aligned, so OR-ing the byte counter into the low bits
    // is the same as adding it.
    function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [1:0]        cnt);
        return base | {{(ADDR_W-2){1'b0}}, cnt};
    endfunction

endpackage

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped instruction cache storage: one 32-bit word per line.
//   clk_i        clock
//   rst_ni       synchronous reset, active-low; clears every valid bit
//   rd_index_i   read index (combinational lookup)
//   rd_tag_i     read tag
//   hit_o        line valid and tag matches
//   rd_data_o    line data (meaningful only with hit_o)
//   we_i         write enable (write lands at the next clock edge)
//   wr_index_i   write index
//   wr_tag_i     write tag
//   wr_data_i    write data
module icache_dm
    import if_fetch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [INDEX_W-1:0] rd_index_i,
    input  logic [TAG_W-1:0]   rd_tag_i,
    output logic               hit_o,
    output logic [INST_W-1:0]  rd_data_o,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [INST_W-1:0]  wr_data_i
);

    logic [ICACHE_LINES-1:0] valid_q;
    logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
    logic [INST_W-1:0]       data_q [ICACHE_LINES];

    // Only the valid bits need reset; stale tag/data are masked by valid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign hit_o     = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_index_i];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: looks up the predicted PC in a direct-mapped I-cache and
// delivers {pc, inst} to IF/ID. A miss is serviced as four byte reads, assembled
// little-endian, written into the line and delivered; a stall is requested meanwhile.
//   clk_in/rst_in        clock / synchronous active-low reset
//   rdy_in               global ready, 0 freezes all state
//   pc_in                fetch PC
//   flush_in             mispredict: abort current fetch
//   stall_in             downstream stall: hold outputs
//   mem_req_out/mem_addr_out, mem_data_valid_in/mem_data_in : byte read interface
//   inst_valid_out/inst_pc_out/inst_out                     : delivered instruction
//   stall_req_out        miss in progress
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush_in,
    input  logic              stall_in,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_data_valid_in,
    input  logic [7:0]        mem_data_in,
    output logic              inst_valid_out,
    output logic [ADDR_W-1:0] inst_pc_out,
    output logic [INST_W-1:0] inst_out,
    output logic              stall_req_out
);

    fetch_state_e      state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] miss_pc_q, miss_pc_d;
    logic [INST_W-1:0] word_q, word_d;
    logic              inst_valid_q, inst_valid_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              stall_req_q, stall_req_d;

    logic              hit;
    logic [INST_W-1:0] hit_data;
    logic              miss_start;
    logic              cache_we;

    icache_dm u_icache (
        .clk_i      (clk_in),
        .rst_ni     (rst_in),
        .rd_index_i (pc_in[INDEX_W+1:2]),
        .rd_tag_i   (pc_in[INDEX_W+TAG_W+1:INDEX_W+2]),
        .hit_o      (hit),
        .rd_data_o  (hit_data),
        .we_i       (cache_we && rdy_in),
        .wr_index_i (miss_pc_q[INDEX_W+1:2]),
        .wr_tag_i   (miss_pc_q[INDEX_W+TAG_W+1:INDEX_W+2]),
        .wr_data_i  (word_q)
    );

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        miss_pc_d    = miss_pc_q;
        word_d       = word_q;
        inst_valid_d = inst_valid_q;
        inst_pc_d    = inst_pc_q;
        inst_d       = inst_q;
        stall_req_d  = stall_req_q;
        miss_start   = 1'b0;
        cache_we     = 1'b0;

        if (flush_in) begin
            // A completed line is still worth keeping; only the delivery is cancelled.
            cache_we     = (state_q == S_FILL);
            state_d      = S_LOOKUP;
            byte_cnt_d   = 2'd0;
            inst_valid_d = 1'b0;
            stall_req_d  = 1'b0;
        end else begin
            case (state_q)
                S_LOOKUP: begin
                    if (!stall_in) begin
                        if (hit) begin
                            inst_valid_d = 1'b1;
                            inst_pc_d    = pc_in;
                            inst_d       = hit_data;
                        end else begin
                            miss_start   = 1'b1;
                            miss_pc_d    = {pc_in[ADDR_W-1:2], 2'b00};
                            byte_cnt_d   = 2'd0;
                            inst_valid_d = 1'b0;
                            stall_req_d  = 1'b1;
                            state_d      = S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // Downstream stall does not block the memory side of a miss.
                    if (mem_data_valid_in) begin
                        word_d[{byte_cnt_q, 3'b000} +: 8] = mem_data_in;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_d = S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    // The line is rewritten every cycle we wait here; harmless.
                    cache_we = 1'b1;
                    if (!stall_in) begin
                        inst_valid_d = 1'b1;
                        inst_pc_d    = miss_pc_q;
                        inst_d       = word_q;
                        stall_req_d  = 1'b0;
                        state_d      = S_LOOKUP;
                    end
                end
                default: begin
                    state_d = S_LOOKUP;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= S_LOOKUP;
            byte_cnt_q   <= 2'd0;
            miss_pc_q    <= '0;
            word_q       <= ZERO_WORD;
            inst_valid_q <= 1'b0;
            inst_pc_q    <= '0;
            inst_q       <= ZERO_WORD;
            stall_req_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            miss_pc_q    <= miss_pc_d;
            word_q       <= word_d;
            inst_valid_q <= inst_valid_d;
            inst_pc_q    <= inst_pc_d;
            inst_q       <= inst_d;
            stall_req_q  <= stall_req_d;
        end
    end

    // Request/address come straight from state, so they are stable while rdy_in is low.
    assign mem_req_out    = (state_q == S_FETCH);
    assign mem_addr_out   = (state_q == S_FETCH) ? fetch_addr(miss_pc_q, byte_cnt_q) : '0;
    assign inst_valid_out = inst_valid_q;
    assign inst_pc_out    = inst_pc_q;
    assign inst_out       = inst_q;
    // The miss cycle raises the stall request before the register catches up.
    assign stall_req_out  = stall_req_q || (miss_start && rdy_in && rst_in);

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic        flush_in = 1'b0;
    logic        stall_in = 1'b1;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_data_valid_in = 1'b0;
    logic [7:0]  mem_data_in = 8'h0;
    logic        inst_valid_out;
    logic [31:0] inst_pc_out;
    logic [31:0] inst_out;
    logic        stall_req_out;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [31:0] addr_log[$];

    if_fetch dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .pc_in             (pc_in),
        .flush_in          (flush_in),
        .stall_in          (stall_in),
        .mem_req_out       (mem_req_out),
        .mem_addr_out      (mem_addr_out),
        .mem_data_valid_in (mem_data_valid_in),
        .mem_data_in       (mem_data_in),
        .inst_valid_out    (inst_valid_out),
        .inst_pc_out       (inst_pc_out),
        .inst_out          (inst_out),
        .stall_req_out     (stall_req_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h000: return 8'h13;
            32'h001: return 8'h05;
            32'h002: return 8'h00;
            32'h003: return 8'h00;
            32'h100: return 8'h93;
            32'h101: return 8'h00;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            32'h200: return 8'h13;
            32'h201: return 8'h01;
            32'h202: return 8'h20;
            32'h203: return 8'h00;
            32'h1FC: return 8'h6F;
            32'h1FD: return 8'h00;
            32'h1FE: return 8'h00;
            32'h1FF: return 8'h00;
            default: return 8'hEE;
        endcase
    endfunction

    // Memory responder: answers every requested byte in the same cycle.
    always @(posedge clk_in) begin
        #2;
        if (mem_req_out && rdy_in && rst_in) begin
            mem_data_valid_in = 1'b1;
            mem_data_in       = mem_byte(mem_addr_out);
            addr_log.push_back(mem_addr_out);
        end else begin
            mem_data_valid_in = 1'b0;
            mem_data_in       = 8'h00;
        end
    end

    // Monitor: a delivery is a valid output following an accepting cycle.
    always @(posedge clk_in) begin
        bit          acc;
        logic [63:0] e;
        acc = rst_in && rdy_in && !stall_in && !flush_in;
        #1;
        if (acc && inst_valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_delivery: got pc=%h inst=%h, required none", inst_pc_out, inst_out);
            end else begin
                e = exp_q.pop_front();
                $display("txn pc=%h inst=%h (expect pc=%h inst=%h)", inst_pc_out, inst_out, e[63:32], e[31:0]);
                if (inst_pc_out !== e[63:32] || inst_out !== e[31:0]) begin
                    failures++;
                    $display("FAIL delivery: got pc=%h inst=%h, required pc=%h inst=%h",
                             inst_pc_out, inst_out, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, {31'b0, mem_req_out}, 32'h0);
        check({tag, "_mem_addr"}, mem_addr_out, 32'h0);
        check({tag, "_inst_valid"}, {31'b0, inst_valid_out}, 32'h0);
        check({tag, "_inst_pc"}, inst_pc_out, 32'h0);
        check({tag, "_inst"}, inst_out, 32'h0);
        check({tag, "_stall_req"}, {31'b0, stall_req_out}, 32'h0);
    endtask

    // One fetch from an idle (stalled) LOOKUP state; returns stalled after delivery.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] inst, input bit miss);
        int lat, stall_cnt, req_cnt;
        bit done;
        exp_q.push_back({pc, inst});
        pc_in = pc;
        stall_in = 1'b0;
        lat = 0; stall_cnt = 0; req_cnt = 0; done = 0;
        while (!done && lat < 40) begin
            @(negedge clk_in);
            if (stall_req_out) stall_cnt++;
            if (mem_req_out) req_cnt++;
            tick();
            lat++;
            if (inst_valid_out) done = 1;
        end
        stall_in = 1'b1;
        check("latency", lat, miss ? 32'd6 : 32'd1);
        check("stall_cycles", stall_cnt, miss ? 32'd6 : 32'd0);
        check("req_cycles", req_cnt, miss ? 32'd4 : 32'd0);
    endtask

    initial begin
        int n;
        // Reset
        repeat (3) tick();
        check_all_zero("reset");
        rst_in = 1'b1;
        tick();

        // 1: cold miss at 0x0
        addr_log.delete();
        do_fetch(32'h0, 32'h00000513, 1);
        check("t1_nbytes", addr_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            check("t1_byte_addr", addr_log[i], i);

        // 2: hit
        do_fetch(32'h0, 32'h00000513, 0);

        // 3: flush after second byte of a miss at 0x100
        pc_in = 32'h100;
        stall_in = 1'b0;
        tick();
        stall_in = 1'b1;
        tick();
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("t3_mem_req", {31'b0, mem_req_out}, 32'h0);
        check("t3_inst_valid", {31'b0, inst_valid_out}, 32'h0);
        check("t3_stall_req", {31'b0, stall_req_out}, 32'h0);
        do_fetch(32'h100, 32'h00100093, 1);

        // 4: alias conflict on index 0, low pc bits ignored
        do_fetch(32'h200, 32'h00200113, 1);
        do_fetch(32'h0, 32'h00000513, 1);
        do_fetch(32'h3, 32'h00000513, 0);
        do_fetch(32'h200, 32'h00200113, 1);
        do_fetch(32'h100, 32'h00100093, 0);

        // 5: downstream stall while in S_FILL (0x0 misses, line holds 0x200)
        exp_q.push_back({32'h0, 32'h00000513});
        pc_in = 32'h0;
        stall_in = 1'b0;
        repeat (5) tick();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("t5_hold_valid", {31'b0, inst_valid_out}, 32'h0);
            check("t5_hold_stall_req", {31'b0, stall_req_out}, 32'h1);
            tick();
        end
        stall_in = 1'b0;
        tick();
        stall_in = 1'b1;
        check("t5_release_valid", {31'b0, inst_valid_out}, 32'h1);
        do_fetch(32'h0, 32'h00000513, 0);

        // 6a: rdy_in low for two cycles mid-fetch at 0x1FC (last index)
        exp_q.push_back({32'h1FC, 32'h0000006F});
        pc_in = 32'h1FC;
        stall_in = 1'b0;
        tick();
        tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            check("t6_frozen_addr", mem_addr_out, 32'h1FD);
            check("t6_frozen_req", {31'b0, mem_req_out}, 32'h1);
            tick();
        end
        rdy_in = 1'b1;
        n = 0;
        while (!inst_valid_out && n < 40) begin
            tick();
            n++;
        end
        stall_in = 1'b1;
        check("t6_resume_cycles", n, 32'd4);
        do_fetch(32'h1FC, 32'h0000006F, 0);

        // 6b: reset in the middle of a miss
        pc_in = 32'h300;
        stall_in = 1'b0;
        tick();
        stall_in = 1'b1;
        tick();
        rst_in = 1'b0;
        tick();
        check_all_zero("midreset");
        rst_in = 1'b1;
        tick();
        do_fetch(32'h0, 32'h00000513, 1);
        do_fetch(32'h100, 32'h00100093, 1);

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
